// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter:
// default bus widths and the arbiter state encoding.
package wb_rr_arbiter_pkg;

    localparam int WB_ADDR_W = 24;
    localparam int WB_DATA_W = 16;
    localparam int WB_SEL_W  = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT0  = 2'd1,
        ARB_GNT1  = 2'd2,
        ARB_ABORT = 2'd3
    } arb_state_t;

    function automatic arb_state_t grant_state(input logic master);
        return master ? ARB_GNT1 : ARB_GNT0;
    endfunction

endpackage

// File: rtl/wb_arb_wdt.sv
// Per-transfer ack watchdog: counts stalled strobe cycles, saturates at
// all-ones and flags a trip when the count is full and the strobe is still unanswered.
module wb_arb_wdt #(
    parameter int WDT_W  = 8,
    parameter bit WDT_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic clear,
    output logic trip
);

    localparam logic [WDT_W-1:0] WDT_MAX = '1;

    generate
        if (WDT_EN) begin : g_wdt
            logic [WDT_W-1:0] count;

            always_ff @(posedge clk) begin
                if (rst || clear || !stall) begin
                    count <= '0;
                end else if (count != WDT_MAX) begin
                    count <= count + 1'b1;
                end
            end

            assign trip = stall && (count == WDT_MAX);
        end else begin : g_no_wdt
            assign trip = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master to one-slave Wishbone arbiter: registered round-robin grant held
// for the whole cycle, combinational bus mux, and watchdog abort of hung transfers.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int SEL_W  = WB_SEL_W,
    parameter int WDT_W  = 8,
    parameter bit WDT_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_o_dat,
    input  logic [SEL_W-1:0]  m0_sel,
    input  logic              m0_4_burst,
    input  logic              m0_8_burst,
    output logic              m0_ack,
    output logic              m0_err,

    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_o_dat,
    input  logic [SEL_W-1:0]  m1_sel,
    input  logic              m1_4_burst,
    input  logic              m1_8_burst,
    output logic              m1_ack,
    output logic              m1_err,

    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_adr,
    output logic [DATA_W-1:0] o_wb_o_dat,
    output logic [SEL_W-1:0]  o_wb_sel,
    output logic              o_wb_4_burst,
    output logic              o_wb_8_burst,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,

    output logic              o_busy,
    output logic              o_wdt_trip
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last;
    logic       last_next;
    logic       slave_stb;
    logic       stall;
    logic       wdt_clear;
    logic       trip;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ARB_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    // In ABORT, 'last' already names the master whose transfer was killed.
    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            ARB_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_next = grant_state(!last);
                end else if (m0_cyc) begin
                    state_next = ARB_GNT0;
                end else if (m1_cyc) begin
                    state_next = ARB_GNT1;
                end
            end
            ARB_GNT0: begin
                if (!m0_cyc) begin
                    last_next  = 1'b0;
                    state_next = m1_cyc ? ARB_GNT1 : ARB_IDLE;
                end else if (trip) begin
                    last_next  = 1'b0;
                    state_next = ARB_ABORT;
                end
            end
            ARB_GNT1: begin
                if (!m1_cyc) begin
                    last_next  = 1'b1;
                    state_next = m0_cyc ? ARB_GNT0 : ARB_IDLE;
                end else if (trip) begin
                    last_next  = 1'b1;
                    state_next = ARB_ABORT;
                end
            end
            ARB_ABORT: begin
                if (!(last ? m1_cyc : m0_cyc)) begin
                    state_next = (last ? m0_cyc : m1_cyc) ? grant_state(!last) : ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign slave_stb = (state == ARB_GNT0) ? (m0_stb && m0_cyc) :
                       (state == ARB_GNT1) ? (m1_stb && m1_cyc) : 1'b0;
    assign stall     = slave_stb && !i_wb_ack && !i_wb_err;
    assign wdt_clear = (state_next != state);

    wb_arb_wdt #(
        .WDT_W  (WDT_W),
        .WDT_EN (WDT_EN)
    ) u_wdt (
        .clk   (i_clk),
        .rst   (i_rst),
        .stall (stall),
        .clear (wdt_clear),
        .trip  (trip)
    );

    always_comb begin
        o_wb_cyc     = 1'b0;
        o_wb_stb     = slave_stb;
        o_wb_we      = 1'b0;
        o_wb_adr     = '0;
        o_wb_o_dat   = '0;
        o_wb_sel     = '0;
        o_wb_4_burst = 1'b0;
        o_wb_8_burst = 1'b0;
        m0_ack       = 1'b0;
        m0_err       = 1'b0;
        m1_ack       = 1'b0;
        m1_err       = 1'b0;
        o_wdt_trip   = 1'b0;
        case (state)
            ARB_GNT0: begin
                o_wb_cyc     = m0_cyc;
                o_wb_we      = m0_we;
                o_wb_adr     = m0_adr;
                o_wb_o_dat   = m0_o_dat;
                o_wb_sel     = m0_sel;
                o_wb_4_burst = m0_4_burst;
                o_wb_8_burst = m0_8_burst;
                m0_ack       = i_wb_ack;
                m0_err       = i_wb_err || trip;
                o_wdt_trip   = trip;
            end
            ARB_GNT1: begin
                o_wb_cyc     = m1_cyc;
                o_wb_we      = m1_we;
                o_wb_adr     = m1_adr;
                o_wb_o_dat   = m1_o_dat;
                o_wb_sel     = m1_sel;
                o_wb_4_burst = m1_4_burst;
                o_wb_8_burst = m1_8_burst;
                m1_ack       = i_wb_ack;
                m1_err       = i_wb_err || trip;
                o_wdt_trip   = trip;
            end
            default: ;
        endcase
    end

    assign o_busy = (state != ARB_IDLE);

endmodule
